capture_readout_sequencer: RTL

Sequences one capture-then-readout cycle of the shared sample RAM. On a start request it drives the write-enable and write address for a full RAM fill. It then drains the RAM to the host link in fixed-length bursts, using a valid/ready handshake per burst. It waits for the link's transfer_done before re-arming, and replaces ad-hoc enable/reset pulsing of the address incrementers with one FSM.

---
 rtl/capture_readout_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/capture_readout_sequencer.sv
`timescale 1ns / 1ps
// capture_readout_sequencer
//
// Runs one capture-then-readout pass over the shared sample RAM.
// A rising edge on start_req fills the RAM (wr_en/wr_addr, one word per
// cycle). The RAM is then drained to the host link in BURST_LEN-word bursts.
// Each burst is offered with burst_valid and read out once burst_ready
// accepts it. The sequencer then waits for transfer_done before re-arming.
//
// Optional build macro: CAPTURE_AUTO_REARM_EN
//   When defined, transfer_done in WAIT_DONE jumps straight into a new
//   capture if start_req is still high. When undefined, every run needs
//   a fresh start_req rising edge.
//
// Ports:
//   variable_clk_2  sole clock, rising edge
//   reset           synchronous, active-high
//   start_req       level start request; its rising edge starts a run
//   burst_ready     host link accepts the offered burst
//   transfer_done   host link finished the final burst (1-cycle pulse)
//   wr_en, wr_addr  RAM write port control during capture
//   rd_en, rd_addr  RAM read port control during a burst
//   burst_valid     burst offered to the host link
//   busy            high in every state except IDLE
//   done            one-cycle pulse at the end of a run
//   state_dbg       current FSM state encoding
module capture_readout_sequencer #(
  parameter int ADDR_WIDTH      = 14,
  parameter int MAX_RAM_ADDRESS = 16384,
  parameter int BURST_LEN       = 8
) (
  input  logic                  variable_clk_2,
  input  logic                  reset,
  input  logic                  start_req,
  input  logic                  burst_ready,
  input  logic                  transfer_done,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  burst_valid,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAPTURE   = 3'd1,
    BURST_REQ = 3'd2,
    BURST_RD  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam int BURST_BITS = $clog2(BURST_LEN);
  // One extra bit so the end-of-readout count is representable even when
  // the RAM spans the full address space.
  localparam logic [ADDR_WIDTH:0] MAX_CNT  = (ADDR_WIDTH + 1)'(MAX_RAM_ADDRESS);
  localparam logic [ADDR_WIDTH:0] LAST_CNT = MAX_CNT - 1'b1;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [ADDR_WIDTH:0]   rd_cnt_reg, rd_cnt_next;
  logic                  done_next;
  logic                  wr_en_reg, rd_en_reg, burst_valid_reg, busy_reg, done_reg;

  // Set once start_req has been seen low. Reset clears it, so a button
  // held through reset must be released before it can start a run.
  logic start_armed_reg;
  logic start_edge;
  logic wr_last;
  logic beat_last;

  assign start_edge = start_req & start_armed_reg;
  assign wr_last    = ({1'b0, wr_addr_reg} == LAST_CNT);
  // Bursts are aligned to BURST_LEN, so the low count bits give the beat.
  assign beat_last  = &rd_cnt_reg[BURST_BITS-1:0];

  always_comb begin
    state_next   = state_reg;
    wr_addr_next = wr_addr_reg;
    rd_cnt_next  = rd_cnt_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next   = CAPTURE;
          wr_addr_next = '0;
          rd_cnt_next  = '0;
        end
      end
      CAPTURE: begin
        if (wr_last) begin
          state_next   = BURST_REQ;
          wr_addr_next = '0;
        end else begin
          wr_addr_next = wr_addr_reg + 1'b1;
        end
      end
      BURST_REQ: begin
        // burst_valid is high for the whole of this state.
        if (burst_ready) begin
          state_next = BURST_RD;
        end
      end
      BURST_RD: begin
        rd_cnt_next = rd_cnt_reg + 1'b1;
        if (beat_last) begin
          state_next = (rd_cnt_next == MAX_CNT) ? WAIT_DONE : BURST_REQ;
        end
      end
      WAIT_DONE: begin
        if (transfer_done) begin
          done_next = 1'b1;
`ifdef CAPTURE_AUTO_REARM_EN
          if (start_req) begin
            state_next   = CAPTURE;
            wr_addr_next = '0;
            rd_cnt_next  = '0;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output flags are registered from the next-state decode so they line
  // up with state_reg and never glitch.
  always_ff @(posedge variable_clk_2) begin
    if (reset) begin
      state_reg       <= IDLE;
      wr_addr_reg     <= '0;
      rd_cnt_reg      <= '0;
      start_armed_reg <= 1'b0;
      wr_en_reg       <= 1'b0;
      rd_en_reg       <= 1'b0;
      burst_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_addr_reg     <= wr_addr_next;
      rd_cnt_reg      <= rd_cnt_next;
      start_armed_reg <= ~start_req;
      wr_en_reg       <= (state_next == CAPTURE);
      rd_en_reg       <= (state_next == BURST_RD);
      burst_valid_reg <= (state_next == BURST_REQ);
      busy_reg        <= (state_next != IDLE);
      done_reg        <= done_next;
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign rd_en       = rd_en_reg;
  assign rd_addr     = rd_cnt_reg[ADDR_WIDTH-1:0];
  assign burst_valid = burst_valid_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign state_dbg   = state_reg;

endmodule
